init_sequencer: RTL and testbench

INIT_SEQUENCER -- requirements
Module: init_sequencer

---
 rtl/pic_pkg.sv | 30 +++
 rtl/init_sequencer_cmd_decode.sv | 62 ++++++
 rtl/init_sequencer.sv | 82 ++++++++
 tb/tb_init_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC initialisation sequencer.
//   - FSM state encodings
//   - one-hot ICW/OCW load-pulse constants (bit0 = ICW1 / OCW1)
//   - bit positions used to decode a register write
package pic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_UNINIT    = 3'd0;
  localparam state_t ST_WAIT_ICW2 = 3'd1;
  localparam state_t ST_WAIT_ICW3 = 3'd2;
  localparam state_t ST_WAIT_ICW4 = 3'd3;
  localparam state_t ST_READY     = 3'd4;

  localparam logic [3:0] ICW1_F = 4'b0001;
  localparam logic [3:0] ICW2_F = 4'b0010;
  localparam logic [3:0] ICW3_F = 4'b0100;
  localparam logic [3:0] ICW4_F = 4'b1000;

  localparam logic [2:0] OCW1_F = 3'b001;
  localparam logic [2:0] OCW2_F = 3'b010;
  localparam logic [2:0] OCW3_F = 3'b100;

  // Data-bus bit positions that steer the decode / ICW1 capture.
  localparam int D4_BIT   = 4;
  localparam int D3_BIT   = 3;
  localparam int SNGL_BIT = 1;
  localparam int IC4_BIT  = 0;

endpackage

// File: rtl/init_sequencer_cmd_decode.sv
// cmd_decode: purely combinational write decoder.
// Inputs : state, wr_stb, a0, d4, d3, and the SNGL/IC4 mode bits latched at ICW1.
// Outputs: state_d (next state), icw_flags/ocw_flags (one-hot, at most one bit
//          set across both), load_icw1 (capture SNGL/IC4), accept (write taken).
module cmd_decode
  import pic_pkg::*;
(
  input  logic [2:0] state,
  input  logic       wr_stb,
  input  logic       a0,
  input  logic       d4,
  input  logic       d3,
  input  logic       sngl,
  input  logic       ic4,
  output logic [2:0] state_d,
  output logic [3:0] icw_flags,
  output logic [2:0] ocw_flags,
  output logic       load_icw1,
  output logic       accept
);

  always_comb begin
    state_d   = state;
    icw_flags = '0;
    ocw_flags = '0;
    load_icw1 = 1'b0;
    if (wr_stb) begin
      // ICW1 restarts initialisation from any state, including READY.
      if (!a0 && d4) begin
        state_d   = ST_WAIT_ICW2;
        icw_flags = ICW1_F;
        load_icw1 = 1'b1;
      end else begin
        // Anything else with A0=0 in a WAIT_* state (D4=0) falls through
        // untouched so a stray OCW cannot abort initialisation.
        case (state)
          ST_WAIT_ICW2: if (a0) begin
            icw_flags = ICW2_F;
            state_d   = !sngl ? ST_WAIT_ICW3 : (ic4 ? ST_WAIT_ICW4 : ST_READY);
          end
          ST_WAIT_ICW3: if (a0) begin
            icw_flags = ICW3_F;
            state_d   = ic4 ? ST_WAIT_ICW4 : ST_READY;
          end
          ST_WAIT_ICW4: if (a0) begin
            icw_flags = ICW4_F;
            state_d   = ST_READY;
          end
          ST_READY: begin
            // D4 is known 0 here (D4=1 with A0=0 was ICW1 above).
            if (a0)       ocw_flags = OCW1_F;
            else if (!d3) ocw_flags = OCW2_F;
            else          ocw_flags = OCW3_F;
          end
          default: ;
        endcase
      end
    end
    accept = (|icw_flags) | (|ocw_flags);
  end

endmodule

// File: rtl/init_sequencer.sv
// init_sequencer: register half of the PIC initialisation sequencer.
// Ports:
//   clk, RST_N (async, active low)
//   WR_STB, A0, DATA_IN[7:0]  - qualified bus write
//   ICWs_Flags[3:0], OCWs_Flags[2:0] - one-cycle one-hot load pulses
//   DATA_Q[7:0]  - write data, updated together with the flag pulse
//   INIT_DONE    - high while in READY
//   SNGL, IC4    - ICW1 D1/D0, captured at each ICW1
// All decode lives in cmd_decode; this module only holds state.
module init_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       RST_N,
  input  logic       WR_STB,
  input  logic       A0,
  input  logic [7:0] DATA_IN,
  output logic [3:0] ICWs_Flags,
  output logic [2:0] OCWs_Flags,
  output logic [7:0] DATA_Q,
  output logic       INIT_DONE,
  output logic       SNGL,
  output logic       IC4
);

  logic [2:0] state_q, state_d;
  logic [3:0] icw_q, icw_d;
  logic [2:0] ocw_q, ocw_d;
  logic [7:0] data_q, data_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic       load_icw1, accept;

  cmd_decode u_dec (
    .state     (state_q),
    .wr_stb    (WR_STB),
    .a0        (A0),
    .d4        (DATA_IN[D4_BIT]),
    .d3        (DATA_IN[D3_BIT]),
    .sngl      (sngl_q),
    .ic4       (ic4_q),
    .state_d   (state_d),
    .icw_flags (icw_d),
    .ocw_flags (ocw_d),
    .load_icw1 (load_icw1),
    .accept    (accept)
  );

  always_comb begin
    data_d = accept    ? DATA_IN           : data_q;
    sngl_d = load_icw1 ? DATA_IN[SNGL_BIT] : sngl_q;
    ic4_d  = load_icw1 ? DATA_IN[IC4_BIT]  : ic4_q;
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_UNINIT;
      icw_q   <= '0;
      ocw_q   <= '0;
      data_q  <= '0;
      sngl_q  <= 1'b0;
      ic4_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      icw_q   <= icw_d;
      ocw_q   <= ocw_d;
      data_q  <= data_d;
      sngl_q  <= sngl_d;
      ic4_q   <= ic4_d;
    end
  end

  // State and flags share a clock edge, so INIT_DONE moves in the same
  // cycle as the final ICW pulse (rise) or the ICW1 pulse (fall).
  assign INIT_DONE  = (state_q == ST_READY);
  assign ICWs_Flags = icw_q;
  assign OCWs_Flags = ocw_q;
  assign DATA_Q     = data_q;
  assign SNGL       = sngl_q;
  assign IC4        = ic4_q;

endmodule

// File: tb/tb_init_sequencer.sv
// Directed self-checking bench for init_sequencer.
module tb_init_sequencer;

  logic       clk = 1'b0;
  logic       RST_N = 1'b0;
  logic       WR_STB = 1'b0;
  logic       A0 = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic [3:0] ICWs_Flags;
  logic [2:0] OCWs_Flags;
  logic [7:0] DATA_Q;
  logic       INIT_DONE, SNGL, IC4;

  int nchk = 0;
  int nerr = 0;

  init_sequencer dut (
    .clk(clk), .RST_N(RST_N), .WR_STB(WR_STB), .A0(A0), .DATA_IN(DATA_IN),
    .ICWs_Flags(ICWs_Flags), .OCWs_Flags(OCWs_Flags), .DATA_Q(DATA_Q),
    .INIT_DONE(INIT_DONE), .SNGL(SNGL), .IC4(IC4)
  );

  always #5 clk = ~clk;

  // Called #1 after a rising edge; drives one write, returns #1 after the
  // edge that samples it, so the outputs then show that write's pulse.
  task automatic wr(input logic a0, input logic [7:0] d);
    WR_STB = 1'b1; A0 = a0; DATA_IN = d;
    @(posedge clk); #1;
    WR_STB = 1'b0; A0 = 1'b0; DATA_IN = 8'h00;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    idle(); idle();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    idle(); idle();
    nchk++; if (ICWs_Flags !== 4'b0000) begin nerr++; $display("FAIL reset_icw: got %b exp 0000", ICWs_Flags); end
    nchk++; if (OCWs_Flags !== 3'b000) begin nerr++; $display("FAIL reset_ocw: got %b exp 000", OCWs_Flags); end
    nchk++; if (DATA_Q !== 8'h00) begin nerr++; $display("FAIL reset_data: got %h exp 00", DATA_Q); end
    nchk++; if ({INIT_DONE, SNGL, IC4} !== 3'b000) begin nerr++; $display("FAIL reset_status: got %b exp 000", {INIT_DONE, SNGL, IC4}); end
    RST_N = 1'b1;
  endtask

  // ICW1 issued in the very first clock after reset release.
  task automatic test_init_single();
    wr(1'b0, 8'h13);
    nchk++; if (ICWs_Flags !== 4'b0001) begin nerr++; $display("FAIL s_icw1: got %b exp 0001", ICWs_Flags); end
    nchk++; if ({SNGL, IC4} !== 2'b11) begin nerr++; $display("FAIL s_mode: got %b exp 11", {SNGL, IC4}); end
    nchk++; if (DATA_Q !== 8'h13) begin nerr++; $display("FAIL s_data1: got %h exp 13", DATA_Q); end
    wr(1'b1, 8'h20);
    nchk++; if (ICWs_Flags !== 4'b0010) begin nerr++; $display("FAIL s_icw2: got %b exp 0010", ICWs_Flags); end
    nchk++; if (INIT_DONE !== 1'b0) begin nerr++; $display("FAIL s_done_early: got %b exp 0", INIT_DONE); end
    wr(1'b1, 8'h01);
    nchk++; if (ICWs_Flags !== 4'b1000) begin nerr++; $display("FAIL s_icw4: got %b exp 1000", ICWs_Flags); end
    nchk++; if (INIT_DONE !== 1'b1) begin nerr++; $display("FAIL s_done: got %b exp 1", INIT_DONE); end
    idle();
    nchk++; if (ICWs_Flags !== 4'b0000) begin nerr++; $display("FAIL s_icw_clear: got %b exp 0000", ICWs_Flags); end
    nchk++; if (DATA_Q !== 8'h01) begin nerr++; $display("FAIL s_data_hold: got %h exp 01", DATA_Q); end
  endtask

  // Back-to-back OCW writes in READY.
  task automatic test_ready_ocw();
    wr(1'b1, 8'hAA);
    nchk++; if ({ICWs_Flags, OCWs_Flags, DATA_Q} !== {4'b0000, 3'b001, 8'hAA}) begin nerr++; $display("FAIL ocw1: got %b %b %h exp 0000 001 aa", ICWs_Flags, OCWs_Flags, DATA_Q); end
    wr(1'b0, 8'h20);
    nchk++; if ({ICWs_Flags, OCWs_Flags, DATA_Q} !== {4'b0000, 3'b010, 8'h20}) begin nerr++; $display("FAIL ocw2: got %b %b %h exp 0000 010 20", ICWs_Flags, OCWs_Flags, DATA_Q); end
    wr(1'b0, 8'h0B);
    nchk++; if ({ICWs_Flags, OCWs_Flags, DATA_Q} !== {4'b0000, 3'b100, 8'h0B}) begin nerr++; $display("FAIL ocw3: got %b %b %h exp 0000 100 0b", ICWs_Flags, OCWs_Flags, DATA_Q); end
    idle();
    nchk++; if ({OCWs_Flags, DATA_Q} !== {3'b000, 8'h0B}) begin nerr++; $display("FAIL ocw_idle: got %b %h exp 000 0b", OCWs_Flags, DATA_Q); end
    nchk++; if (INIT_DONE !== 1'b1) begin nerr++; $display("FAIL ocw_done: got %b exp 1", INIT_DONE); end
  endtask

  // Re-initialisation from READY; SNGL=1/IC4=0 so ICW2 finishes init.
  task automatic test_reinit();
    wr(1'b0, 8'h12);
    nchk++; if (ICWs_Flags !== 4'b0001) begin nerr++; $display("FAIL re_icw1: got %b exp 0001", ICWs_Flags); end
    nchk++; if (INIT_DONE !== 1'b0) begin nerr++; $display("FAIL re_done_fall: got %b exp 0", INIT_DONE); end
    nchk++; if ({SNGL, IC4} !== 2'b10) begin nerr++; $display("FAIL re_mode: got %b exp 10", {SNGL, IC4}); end
    wr(1'b1, 8'h40);
    nchk++; if ({ICWs_Flags, INIT_DONE} !== {4'b0010, 1'b1}) begin nerr++; $display("FAIL re_icw2: got %b %b exp 0010 1", ICWs_Flags, INIT_DONE); end
  endtask

  // Cascade mode, no ICW4.
  task automatic test_init_cascade();
    wr(1'b0, 8'h10);
    nchk++; if ({ICWs_Flags, SNGL, IC4, INIT_DONE} !== {4'b0001, 3'b000}) begin nerr++; $display("FAIL c_icw1: got %b %b%b%b exp 0001 000", ICWs_Flags, SNGL, IC4, INIT_DONE); end
    wr(1'b1, 8'h08);
    nchk++; if ({ICWs_Flags, INIT_DONE} !== {4'b0010, 1'b0}) begin nerr++; $display("FAIL c_icw2: got %b %b exp 0010 0", ICWs_Flags, INIT_DONE); end
    wr(1'b1, 8'h04);
    nchk++; if ({ICWs_Flags, INIT_DONE} !== {4'b0100, 1'b1}) begin nerr++; $display("FAIL c_icw3: got %b %b exp 0100 1", ICWs_Flags, INIT_DONE); end
    // Next A0=1 write must be OCW1, not ICW4.
    wr(1'b1, 8'h77);
    nchk++; if ({ICWs_Flags, OCWs_Flags} !== {4'b0000, 3'b001}) begin nerr++; $display("FAIL c_no_icw4: got %b %b exp 0000 001", ICWs_Flags, OCWs_Flags); end
  endtask

  task automatic test_ignore();
    do_reset();
    wr(1'b1, 8'h55);
    nchk++; if ({ICWs_Flags, OCWs_Flags, DATA_Q} !== {4'b0000, 3'b000, 8'h00}) begin nerr++; $display("FAIL ig_uninit: got %b %b %h exp 0000 000 00", ICWs_Flags, OCWs_Flags, DATA_Q); end
    wr(1'b0, 8'h13);
    wr(1'b0, 8'h08);
    nchk++; if ({ICWs_Flags, OCWs_Flags, DATA_Q} !== {4'b0000, 3'b000, 8'h13}) begin nerr++; $display("FAIL ig_wait: got %b %b %h exp 0000 000 13", ICWs_Flags, OCWs_Flags, DATA_Q); end
    wr(1'b1, 8'h20);
    nchk++; if ({ICWs_Flags, DATA_Q} !== {4'b0010, 8'h20}) begin nerr++; $display("FAIL ig_icw2: got %b %h exp 0010 20", ICWs_Flags, DATA_Q); end
  endtask

  task automatic test_reset_mid();
    wr(1'b0, 8'h10);
    wr(1'b1, 8'h08);
    RST_N = 1'b0;
    #1;
    nchk++; if ({ICWs_Flags, OCWs_Flags, DATA_Q, INIT_DONE, SNGL, IC4} !== 18'd0) begin nerr++; $display("FAIL mid_async: got %b %b %h %b%b%b exp all 0", ICWs_Flags, OCWs_Flags, DATA_Q, INIT_DONE, SNGL, IC4); end
    @(posedge clk); #1;
    RST_N = 1'b1;
    wr(1'b1, 8'h04);
    nchk++; if ({ICWs_Flags, OCWs_Flags, DATA_Q, INIT_DONE} !== 16'd0) begin nerr++; $display("FAIL mid_ignore: got %b %b %h %b exp all 0", ICWs_Flags, OCWs_Flags, DATA_Q, INIT_DONE); end
    wr(1'b0, 8'h13);
    nchk++; if (ICWs_Flags !== 4'b0001) begin nerr++; $display("FAIL mid_icw1: got %b exp 0001", ICWs_Flags); end
  endtask

  initial begin
    #1;
    test_reset();
    test_init_single();
    test_ready_ocw();
    test_reinit();
    test_init_cascade();
    test_ignore();
    test_reset_mid();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
